// File: rtl/refclk_ctrl_if.sv
// Bundles the configuration, counter and divider signals of refclk_ctrl.
// The master side drives requests and refclk; the slave side is the controller.
interface refclk_ctrl_if #(
  parameter int BW = 8,
  parameter int CW = 16
);
  logic          cfg_wr;
  logic [BW-1:0] cfg_div;
  logic          cfg_ack;
  logic          cfg_busy;
  logic          cnt_start;
  logic          cnt_stop;
  logic          auto_reload;
  logic [CW-1:0] cmp_val;
  logic          refclk;
  logic [BW-1:0] ref_st;
  logic [CW-1:0] cnt;
  logic          irq;
  logic          running;

  modport master (
    output cfg_wr, cfg_div, cnt_start, cnt_stop, auto_reload, cmp_val, refclk,
    input  cfg_ack, cfg_busy, ref_st, cnt, irq, running
  );

  modport slave (
    input  cfg_wr, cfg_div, cnt_start, cnt_stop, auto_reload, cmp_val, refclk,
    output cfg_ack, cfg_busy, ref_st, cnt, irq, running
  );
endinterface

// File: rtl/refclk_ctrl.sv
// Reference-clock controller: applies divider ratio changes only on refclk
// rising edges and counts refclk periods against a compare value.
module refclk_ctrl #(
  parameter int BW      = 8,
  parameter int CW      = 16,
  parameter int DEF_DIV = 15
) (
  input logic          clk,
  input logic          rst_n,
  refclk_ctrl_if.slave bus
);
  localparam logic [1:0]    ST_STOP  = 2'd0;
  localparam logic [1:0]    ST_RUN   = 2'd1;
  localparam logic [1:0]    ST_PEND  = 2'd2;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [BW-1:0] DIV_RST  = BW'(DEF_DIV);

  logic [1:0]    state_r,  state_s;
  logic [BW-1:0] shadow_r, shadow_s;
  logic [BW-1:0] ref_st_r, ref_st_s;
  logic [CW-1:0] cnt_r,    cnt_s;
  logic          refclk_q_r;
  logic          apply_r,   apply_s;
  logic          irq_r,     irq_s;
  logic          ack_r,     ack_s;
  logic          busy_r,    busy_s;
  logic          running_r, running_s;
  logic          edge_s, hit_s, stop_s;

  assign edge_s = bus.refclk & ~refclk_q_r;
  assign hit_s  = edge_s && (bus.cmp_val != CNT_ZERO) && (cnt_r == (bus.cmp_val - CNT_ONE));
  // A one-shot terminal count stops the counter exactly like cnt_stop does.
  assign stop_s = (state_r != ST_STOP) && (bus.cnt_stop || (hit_s && !bus.auto_reload));

  // Next-state logic; apply_r carries a ratio written while stopped into ref_st one cycle later.
  always_comb begin
    state_s   = state_r;
    shadow_s  = shadow_r;
    ref_st_s  = ref_st_r;
    cnt_s     = cnt_r;
    irq_s     = 1'b0;
    ack_s     = 1'b0;
    busy_s    = busy_r;
    apply_s   = 1'b0;
    if (apply_r) begin
      ref_st_s = shadow_r;
      ack_s    = 1'b1;
    end else begin
      ref_st_s = ref_st_r;
    end
    if ((state_r != ST_STOP) && edge_s) begin
      if (hit_s) begin
        cnt_s = CNT_ZERO;
        irq_s = 1'b1;
      end else begin
        cnt_s = cnt_r + CNT_ONE;
      end
    end else begin
      cnt_s = cnt_r;
    end
    case (state_r)
      ST_STOP: begin
        busy_s = 1'b0;
        if (bus.cfg_wr) begin
          shadow_s = bus.cfg_div;
          apply_s  = 1'b1;
        end else begin
          apply_s = 1'b0;
        end
        if (bus.cnt_start && !bus.cnt_stop) begin
          cnt_s   = CNT_ZERO;
          state_s = ST_RUN;
        end else begin
          state_s = ST_STOP;
        end
      end
      ST_RUN: begin
        if (stop_s) begin
          state_s = ST_STOP;
          if (bus.cfg_wr) begin
            shadow_s = bus.cfg_div;
            apply_s  = 1'b1;
          end else begin
            apply_s = 1'b0;
          end
        end else if (bus.cfg_wr) begin
          shadow_s = bus.cfg_div;
          busy_s   = 1'b1;
          state_s  = ST_PEND;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_PEND: begin
        if (edge_s || stop_s) begin
          ref_st_s = shadow_r;
          ack_s    = 1'b1;
          busy_s   = 1'b0;
          state_s  = stop_s ? ST_STOP : ST_RUN;
          if (bus.cfg_wr) begin
            shadow_s = bus.cfg_div;
            if (stop_s) begin
              apply_s = 1'b1;
            end else begin
              busy_s  = 1'b1;
              state_s = ST_PEND;
            end
          end else begin
            shadow_s = shadow_r;
          end
        end else if (bus.cfg_wr) begin
          shadow_s = bus.cfg_div;
        end else begin
          shadow_s = shadow_r;
        end
      end
      default: begin
        state_s = ST_STOP;
        busy_s  = 1'b0;
      end
    endcase
    running_s = (state_s != ST_STOP);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_STOP;
      shadow_r   <= DIV_RST;
      ref_st_r   <= DIV_RST;
      cnt_r      <= CNT_ZERO;
      refclk_q_r <= 1'b0;
      apply_r    <= 1'b0;
      irq_r      <= 1'b0;
      ack_r      <= 1'b0;
      busy_r     <= 1'b0;
      running_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      shadow_r   <= shadow_s;
      ref_st_r   <= ref_st_s;
      cnt_r      <= cnt_s;
      refclk_q_r <= bus.refclk;
      apply_r    <= apply_s;
      irq_r      <= irq_s;
      ack_r      <= ack_s;
      busy_r     <= busy_s;
      running_r  <= running_s;
    end
  end

  assign bus.ref_st   = ref_st_r;
  assign bus.cnt      = cnt_r;
  assign bus.irq      = irq_r;
  assign bus.cfg_ack  = ack_r;
  assign bus.cfg_busy = busy_r;
  assign bus.running  = running_r;
endmodule

// File: tb/tb_refclk_ctrl.sv
// Bench for refclk_ctrl driven by a ratio-controlled divider (period = ratio+1 clk),
// checked every cycle against a flag-based behavioural model plus directed scenario checks.
module tb_refclk_ctrl;
  localparam int BW  = 8;
  localparam int CW  = 4;
  localparam int DEF = 15;
  localparam int MOD = 1 << CW;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   irq_cnt  = 0;
  int   ack_cnt  = 0;
  bit   wrapped  = 1'b0;
  int   prev_cnt = 0;
  int   irq_t[$];
  int   dcnt;

  // behavioural model state
  bit m_run, m_pend, m_busy, m_apply, m_irq, m_ack, m_refq;
  int m_ref, m_sh, m_cnt;

  refclk_ctrl_if #(.BW(BW), .CW(CW)) bus ();

  refclk_ctrl #(.BW(BW), .CW(CW), .DEF_DIV(DEF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // divider: one-cycle-high refclk every ref_st+1 clocks, updated away from posedge
  always @(negedge clk) begin
    if (!rst_n) begin
      dcnt       = 0;
      bus.refclk = 1'b0;
    end else if (dcnt >= int'(bus.ref_st)) begin
      dcnt       = 0;
      bus.refclk = 1'b1;
    end else begin
      dcnt       = dcnt + 1;
      bus.refclk = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit edge_m, done, stop;
    int cv;
    if (!rst_n) begin
      m_run = 0; m_pend = 0; m_busy = 0; m_apply = 0;
      m_ref = DEF; m_sh = DEF; m_cnt = 0;
      m_irq = 0; m_ack = 0; m_refq = 0;
    end else begin
      edge_m = bus.refclk && !m_refq;
      m_refq = bus.refclk;
      m_irq  = 0;
      m_ack  = 0;
      cv     = int'(bus.cmp_val);
      if (m_apply) begin
        m_ref = m_sh;
        m_ack = 1;
      end
      m_apply = 0;
      if (!m_run) begin
        m_busy = 0;
        if (bus.cfg_wr) begin
          m_sh    = int'(bus.cfg_div);
          m_apply = 1;
        end
        if (bus.cnt_start && !bus.cnt_stop) begin
          m_cnt = 0;
          m_run = 1;
        end
      end else begin
        done = 0;
        if (edge_m) begin
          if (cv != 0 && m_cnt == cv - 1) begin
            m_irq = 1;
            m_cnt = 0;
            done  = !bus.auto_reload;
          end else begin
            m_cnt = (m_cnt + 1) % MOD;
          end
        end
        stop = bus.cnt_stop || done;
        if (m_pend && (edge_m || stop)) begin
          m_ref  = m_sh;
          m_ack  = 1;
          m_pend = 0;
          m_busy = 0;
        end
        if (stop) begin
          m_run  = 0;
          m_pend = 0;
          m_busy = 0;
          if (bus.cfg_wr) begin
            m_sh    = int'(bus.cfg_div);
            m_apply = 1;
          end
        end else if (bus.cfg_wr) begin
          m_sh   = int'(bus.cfg_div);
          m_pend = 1;
          m_busy = 1;
        end
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    chk("ref_st",   32'(bus.ref_st),   m_ref);
    chk("cnt",      32'(bus.cnt),      m_cnt);
    chk("irq",      32'(bus.irq),      32'(m_irq));
    chk("cfg_ack",  32'(bus.cfg_ack),  32'(m_ack));
    chk("cfg_busy", 32'(bus.cfg_busy), 32'(m_busy));
    chk("running",  32'(bus.running),  32'(m_run));
    if (bus.irq === 1'b1) begin
      irq_cnt++;
      irq_t.push_back(cyc);
    end
    if (bus.cfg_ack === 1'b1) ack_cnt++;
    if (prev_cnt == MOD - 1 && int'(bus.cnt) == 0) wrapped = 1'b1;
    prev_cnt = int'(bus.cnt);
    @(negedge clk);
    #2;
  endtask

  // advance until the divider presents a rising refclk, then consume that edge
  task automatic pass_edge();
    int k = 0;
    while (bus.refclk !== 1'b1 && k < 64) begin
      tick();
      k++;
    end
    chk("wait_refclk", 32'(bus.refclk), 32'd1);
    tick();
  endtask

  initial begin
    int n;
    rst_n           = 1'b0;
    bus.cfg_wr      = 1'b0;
    bus.cfg_div     = 8'd0;
    bus.cnt_start   = 1'b0;
    bus.cnt_stop    = 1'b0;
    bus.auto_reload = 1'b1;
    bus.cmp_val     = 4'd0;
    @(negedge clk);
    #2;
    tick();
    tick();
    chk("rst_ref_st", 32'(bus.ref_st), 32'd15);
    rst_n = 1'b1;

    // ratio load while stopped
    bus.cfg_wr = 1'b1; bus.cfg_div = 8'd3;
    tick();
    bus.cfg_wr = 1'b0;
    tick();
    chk("stop_ref3", 32'(bus.ref_st), 32'd3);
    chk("stop_ack",  32'(bus.cfg_ack), 32'd1);
    bus.cfg_wr = 1'b1; bus.cfg_div = 8'd15;
    tick();
    bus.cfg_wr = 1'b0;
    tick();

    // periodic counting at ratio 15: irq every 64 clk
    bus.cmp_val = 4'd4; bus.auto_reload = 1'b1; bus.cnt_start = 1'b1;
    tick();
    bus.cnt_start = 1'b0;
    irq_t.delete();
    repeat (220) tick();
    chk("irq_count_ge3", 32'(irq_t.size() >= 3), 32'd1);
    if (irq_t.size() >= 3) begin
      chk("irq_gap0", 32'(irq_t[1] - irq_t[0]), 32'd64);
      chk("irq_gap1", 32'(irq_t[2] - irq_t[1]), 32'd64);
    end

    // two writes before the next edge: single ack, last value wins
    pass_edge();
    bus.cfg_wr = 1'b1; bus.cfg_div = 8'd7;
    tick();
    bus.cfg_div = 8'd1;
    tick();
    bus.cfg_wr = 1'b0;
    ack_cnt = 0;
    repeat (20) tick();
    chk("pend_single_ack", 32'(ack_cnt), 32'd1);
    chk("pend_ref1", 32'(bus.ref_st), 32'd1);
    pass_edge();
    n = 1;
    while (bus.refclk !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("refclk_period", 32'(n), 32'd2);
    bus.cnt_stop = 1'b1;
    tick();
    bus.cnt_stop = 1'b0;
    tick();

    // one-shot
    bus.cmp_val = 4'd2; bus.auto_reload = 1'b0; bus.cnt_start = 1'b1;
    tick();
    bus.cnt_start = 1'b0;
    irq_cnt = 0;
    repeat (30) tick();
    chk("oneshot_irqs", 32'(irq_cnt), 32'd1);
    chk("oneshot_running", 32'(bus.running), 32'd0);
    chk("oneshot_cnt", 32'(bus.cnt), 32'd0);

    // start and stop together from STOP
    bus.cnt_start = 1'b1; bus.cnt_stop = 1'b1;
    tick();
    bus.cnt_start = 1'b0; bus.cnt_stop = 1'b0;
    tick();
    chk("start_stop_running", 32'(bus.running), 32'd0);

    // stop while a ratio change is pending
    bus.cfg_wr = 1'b1; bus.cfg_div = 8'd15;
    tick();
    bus.cfg_wr = 1'b0;
    tick();
    bus.cmp_val = 4'd5; bus.auto_reload = 1'b1; bus.cnt_start = 1'b1;
    tick();
    bus.cnt_start = 1'b0;
    pass_edge();
    bus.cfg_wr = 1'b1; bus.cfg_div = 8'd9;
    tick();
    bus.cfg_wr = 1'b0;
    chk("pend_busy", 32'(bus.cfg_busy), 32'd1);
    bus.cnt_stop = 1'b1;
    tick();
    bus.cnt_stop = 1'b0;
    chk("stop_pend_ack", 32'(bus.cfg_ack), 32'd1);
    chk("stop_pend_ref", 32'(bus.ref_st), 32'd9);
    chk("stop_pend_running", 32'(bus.running), 32'd0);

    // cmp_val = 0: free-running wrap, no irq
    bus.cfg_wr = 1'b1; bus.cfg_div = 8'd1;
    tick();
    bus.cfg_wr = 1'b0;
    tick();
    bus.cmp_val = 4'd0; bus.cnt_start = 1'b1;
    tick();
    bus.cnt_start = 1'b0;
    irq_cnt = 0;
    wrapped = 1'b0;
    repeat (50) tick();
    chk("cmp0_irqs", 32'(irq_cnt), 32'd0);
    chk("cmp0_wrap", 32'(wrapped), 32'd1);

    // reset while pending discards the ratio
    pass_edge();
    bus.cfg_wr = 1'b1; bus.cfg_div = 8'd5;
    tick();
    bus.cfg_wr = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ack_cnt = 0;
    repeat (10) tick();
    chk("rst_pend_ack", 32'(ack_cnt), 32'd0);
    chk("rst_pend_ref", 32'(bus.ref_st), 32'd15);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      bus.cfg_wr      = ($urandom_range(0, 7) == 0);
      bus.cfg_div     = 8'($urandom_range(1, 3));
      bus.cnt_start   = ($urandom_range(0, 7) == 0);
      bus.cnt_stop    = ($urandom_range(0, 19) == 0);
      bus.auto_reload = ($urandom_range(0, 3) != 0);
      bus.cmp_val     = 4'($urandom_range(0, 5));
      rst_n           = ($urandom_range(0, 149) != 0);
      tick();
    end
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/refclk_ctrl.md
REFCLK_CTRL -- requirements
Module: refclk_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- BW, 8, divider ratio width.
- CW, 16, period counter width.
- DEF_DIV, 15, divider ratio after reset.
REQ-002 Ports SHALL be, one per line: name direction width meaning.
- clk in 1: single system clock.
- rst_n in 1: reset, synchronous, active-low.
- cfg_wr in 1: one-cycle request to load a new divider ratio.
- cfg_div in BW: new ratio, sampled when cfg_wr=1.
- cfg_ack out 1: one-cycle pulse when the new ratio reaches ref_st.
- cfg_busy out 1: high while a ratio change is pending.
- cnt_start in 1: start period counting.
- cnt_stop in 1: stop period counting.
- auto_reload in 1: 1 means periodic, 0 means one-shot.
- cmp_val in CW: refclk periods per event.
- refclk in 1: divided clock from the controlled divider.
- ref_st out BW: ratio driven to the divider.
- cnt out CW: current period count.
- irq out 1: one-cycle event pulse.
- running out 1: high in RUN or PEND.

Function
REQ-003 Block SHALL register refclk into refclk_q and define edge = refclk & ~refclk_q.
REQ-004 FSM SHALL have exactly three states: STOP, RUN and PEND.
REQ-005 In STOP, cfg_wr SHALL latch cfg_div into a shadow register and load ref_st on the following clock edge, with cfg_ack high in that same cycle; busy SHALL never assert.
REQ-006 cnt_start in STOP SHALL clear cnt to 0 and enter RUN on the next cycle.
REQ-007 In RUN, cfg_wr SHALL latch the shadow register, set cfg_busy the next cycle and enter PEND; ref_st SHALL NOT change outside an edge.
REQ-008 In PEND, the first edge SHALL make ref_st equal the shadow value, pulse cfg_ack, clear cfg_busy and return to RUN, all registered and visible one cycle after the edge cycle.
REQ-009 A cfg_wr in PEND SHALL overwrite the shadow value without an extra ack; only the last value is applied.
REQ-010 A cfg_wr in the same cycle as the applying edge SHALL be captured and remain in PEND for the next edge.
REQ-011 In RUN or PEND, each edge SHALL increment cnt by 1, modulo 2^CW.
REQ-012 When an edge occurs and cnt equals cmp_val-1 with cmp_val != 0, irq SHALL pulse for one cycle.
- auto_reload=1: cnt SHALL go to 0 and counting continues.
- auto_reload=0: cnt SHALL go to 0 and the FSM SHALL enter STOP (PEND is resolved first per REQ-014).
REQ-013 cmp_val=0 SHALL never raise irq; cnt free-runs and wraps from 2^CW-1 to 0.
REQ-014 cnt_stop in RUN SHALL enter STOP next cycle and hold cnt. In PEND it SHALL also apply the shadow value to ref_st with a cfg_ack pulse that same cycle.
REQ-015 Simultaneous cnt_start and cnt_stop SHALL be resolved as stop. cnt_start in RUN or PEND SHALL be ignored.
REQ-016 If an edge and cnt_stop coincide, the edge SHALL be counted (including any irq) before stopping.
REQ-017 cmp_val and auto_reload SHALL be sampled on every edge and need not be held static.
REQ-018 All outputs SHALL be registered; running = (state != STOP).

Reset
REQ-019 With rst_n=0 at a clk edge, the next cycle SHALL show:
- state STOP, ref_st=DEF_DIV, shadow=DEF_DIV
- cnt=0, irq=0, cfg_ack=0, cfg_busy=0, running=0, refclk_q=0
REQ-020 Reset mid-PEND SHALL discard the pending ratio and issue no ack.
REQ-021 There SHALL be no asynchronous behaviour; rst_n SHALL only be sampled at posedge clk.

Verification
REQ-022 Bench SHALL pair refclk_ctrl with the divider (BW=8) and cover:
- STOP, cfg_wr cfg_div=3 -> ref_st=3 and cfg_ack one cycle later, cfg_busy never 1.
- cnt_start, cmp_val=4, auto_reload=1, ref_st=15 -> irq every 64 clk, cnt sequence 0,1,2,3,0.
- RUN, cfg_wr 7 then cfg_wr 1 before the edge -> a single ack, ref_st=1 exactly one cycle after the next edge, refclk period becomes 2 clk.
- auto_reload=0, cmp_val=2 -> one irq, then running=0 and cnt=0, no further irq.
- cnt_start and cnt_stop together from STOP -> stays STOP; cnt_stop during PEND -> ack, ref_st updated, running=0.
- cmp_val=0, CW=4 -> cnt wraps 15->0, no irq; rst_n=0 mid-PEND -> ref_st=15, no ack.
